// File: rtl/speed_selector_pkg.sv
// Shared types and default constants for the speed selector.
// The repeat FSM state, step direction and counter sizing helper live here.
package speed_selector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  localparam int         DEF_DEBOUNCE_CYCLES = 50000;
  localparam int         DEF_REPEAT_DELAY    = 10000000;
  localparam int         DEF_REPEAT_PERIOD   = 2000000;
  localparam logic [7:0] DEF_RESET_INDEX     = 8'd0;

  // Bits needed to count 0 .. limit-1, never narrower than one bit.
  function automatic int count_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/speed_selector_button.sv
// One button channel: two-flop synchronizer, debounce counter and press pulse.
// The synchronizer always runs; the debounce state only advances while enabled.
module button_debouncer
  import speed_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = count_width(DEBOUNCE_CYCLES);

  logic          sync_a;
  logic          sync_b;
  logic          level_d;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES back-to-back disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= 1'b0;
      level_d <= 1'b0;
      count   <= '0;
    end else if (ena) begin
      level_d <= level;
      if (sync_b == level) begin
        count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_b;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/speed_selector.sv
// Up/down speed index selector with debounced buttons and hold-to-repeat.
// Emits a registered 8-bit index and a one-cycle pulse whenever it changes.
module speed_selector
  import speed_selector_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int         REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int         REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [7:0] RESET_INDEX     = DEF_RESET_INDEX
) (
  input  logic       i_clkPin,
  input  logic       i_rst,
  input  logic       i_ena,
  input  logic       i_btnUp,
  input  logic       i_btnDown,
  output logic [7:0] o_indexSelectLine,
  output logic       o_changed
);

  localparam int CW = count_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  logic          up_level;
  logic          up_press;
  logic          down_level;
  logic          down_press;
  state_t        state;
  state_t        state_nxt;
  dir_t          dir;
  dir_t          dir_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] count_limit;
  logic          held_level;
  logic          other_level;
  logic          step_up;
  logic          step_down;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (i_clkPin),
    .rst   (i_rst),
    .ena   (i_ena),
    .raw   (i_btnUp),
    .level (up_level),
    .press (up_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk   (i_clkPin),
    .rst   (i_rst),
    .ena   (i_ena),
    .raw   (i_btnDown),
    .level (down_level),
    .press (down_press)
  );

  assign held_level  = (dir == DIR_UP) ? up_level : down_level;
  assign other_level = (dir == DIR_UP) ? down_level : up_level;
  assign count_limit = (state == ST_DELAY) ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_PERIOD - 1);

  always_ff @(posedge i_clkPin or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      dir   <= DIR_UP;
      count <= '0;
    end else if (i_ena) begin
      state <= state_nxt;
      dir   <= dir_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    count_nxt = count;
    step_up   = 1'b0;
    step_down = 1'b0;
    case (state)
      ST_IDLE: begin
        if (up_press && !down_level) begin
          step_up   = 1'b1;
          dir_nxt   = DIR_UP;
          count_nxt = '0;
          state_nxt = ST_DELAY;
        end else if (down_press && !up_level) begin
          step_down = 1'b1;
          dir_nxt   = DIR_DOWN;
          count_nxt = '0;
          state_nxt = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        // Release or a conflicting button wins over a due repeat step.
        if (!held_level || other_level) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end else if (count == count_limit) begin
          step_up   = (dir == DIR_UP);
          step_down = (dir == DIR_DOWN);
          count_nxt = '0;
          state_nxt = ST_REPEAT;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clkPin or posedge i_rst) begin
    if (i_rst) begin
      o_indexSelectLine <= RESET_INDEX;
      o_changed         <= 1'b0;
    end else if (!i_ena) begin
      o_changed <= 1'b0;
    end else if (step_up && !step_down && (o_indexSelectLine != 8'hFF)) begin
      o_indexSelectLine <= o_indexSelectLine + 8'd1;
      o_changed         <= 1'b1;
    end else if (step_down && !step_up && (o_indexSelectLine != 8'h00)) begin
      o_indexSelectLine <= o_indexSelectLine - 8'd1;
      o_changed         <= 1'b1;
    end else begin
      o_changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_speed_selector.sv
// Directed bench for speed_selector: expected {cycle, index} pairs are queued
// by the drivers and popped by a monitor on every o_changed pulse.
module tb_speed_selector;
  import speed_selector_pkg::*;

  localparam int W = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [7:0] index;
  logic       changed;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_pulse = 0;
  logic [7:0] mdl_idx = 8'd0;
  logic [W-1:0] exp_q[$];

  speed_selector #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5),
    .RESET_INDEX     (8'd0)
  ) dut (
    .i_clkPin          (clk),
    .i_rst             (rst),
    .i_ena             (ena),
    .i_btnUp           (btn_up),
    .i_btnDown         (btn_down),
    .o_indexSelectLine (index),
    .o_changed         (changed)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model of step timing for a button whose raw level first samples high at
  // edge t0+1: press step lands at t0+7, delay step at t0+27, then every 5.
  task automatic push_steps(input bit up, input int t0, input int last_edge);
    int e;
    e = t0 + 7;
    while (e <= last_edge) begin
      if (up && mdl_idx != 8'hFF) begin
        mdl_idx++;
        exp_q.push_back({32'(e), mdl_idx});
      end else if (!up && mdl_idx != 8'h00) begin
        mdl_idx--;
        exp_q.push_back({32'(e), mdl_idx});
      end
      e = (e == t0 + 7) ? t0 + 27 : e + 5;
    end
  endtask

  task automatic hold_btn(input bit up, input int h);
    int t0;
    @(negedge clk);
    t0 = cyc;
    push_steps(up, t0, t0 + h + 6);
    if (up) btn_up = 1'b1;
    else btn_down = 1'b1;
    repeat (h) @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mdl_idx = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (changed) begin
      n_pulse++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got index %0d at cycle %0d, expected no pulse", index, cyc);
      end else begin
        logic [W-1:0] exp_e;
        exp_e = exp_q.pop_front();
        if ({32'(cyc), index} !== exp_e) begin
          n_fail++;
          $display("FAIL pulse: got index %0d at cycle %0d, expected index %0d at cycle %0d",
                   index, cyc, exp_e[7:0], exp_e[W-1:8]);
        end
      end
    end
  end

  initial begin
    int t0;
    int p0;

    // reset state
    repeat (2) @(negedge clk);
    check("reset_index", 32'(index), 32'd0);
    check("reset_changed", 32'(changed), 32'd0);
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // clean press: one step 6 cycles after first sample
    hold_btn(1'b1, 10);
    check("single_press_index", 32'(index), 32'd1);

    // bouncy input never settles long enough
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      btn_up = ((i % 4) < 2);
    end
    btn_up = 1'b0;
    repeat (15) @(negedge clk);
    check("bounce_index", 32'(index), 32'd1);

    // disabled: nothing advances
    @(negedge clk);
    ena = 1'b0;
    btn_up = 1'b1;
    repeat (20) @(negedge clk);
    check("ena_low_index", 32'(index), 32'd1);
    btn_up = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    repeat (10) @(negedge clk);
    check("ena_restore_index", 32'(index), 32'd1);

    // auto-repeat from 0 for 60 cycles
    do_reset();
    repeat (3) @(negedge clk);
    p0 = n_pulse;
    hold_btn(1'b1, 60);
    check("repeat_index", 32'(index), 32'd9);
    check("repeat_pulses", 32'(n_pulse - p0), 32'd9);

    // saturation at the top, then a fresh up press at 255
    hold_btn(1'b1, 1300);
    check("sat_top_index", 32'(index), 32'd255);
    p0 = n_pulse;
    hold_btn(1'b1, 10);
    check("sat_top_press", 32'(index), 32'd255);
    check("sat_top_pulses", 32'(n_pulse - p0), 32'd0);

    // saturation at the bottom
    do_reset();
    repeat (3) @(negedge clk);
    p0 = n_pulse;
    hold_btn(1'b0, 10);
    check("sat_bottom_index", 32'(index), 32'd0);
    check("sat_bottom_pulses", 32'(n_pulse - p0), 32'd0);

    // up repeating, down pressed: repeat stops at 5 steps
    @(negedge clk);
    t0 = cyc;
    push_steps(1'b1, t0, t0 + 46);
    btn_up = 1'b1;
    repeat (40) @(negedge clk);
    btn_down = 1'b1;
    repeat (30) @(negedge clk);
    check("conflict_index", 32'(index), 32'd5);
    check("conflict_state", 32'(dut.state), 32'(ST_IDLE));
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (15) @(negedge clk);

    // both pressed together from idle
    p0 = n_pulse;
    @(negedge clk);
    btn_up = 1'b1;
    btn_down = 1'b1;
    repeat (30) @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (15) @(negedge clk);
    check("both_index", 32'(index), 32'd5);
    check("both_pulses", 32'(n_pulse - p0), 32'd0);

    // async reset mid-repeat at index 40
    @(negedge clk);
    t0 = cyc;
    push_steps(1'b1, t0, t0 + 192);
    btn_up = 1'b1;
    repeat (194) @(negedge clk);
    check("pre_reset_index", 32'(index), 32'd40);
    check("pre_reset_state", 32'(dut.state), 32'(ST_REPEAT));
    #2;
    rst = 1'b1;
    mdl_idx = 8'd0;
    #1;
    check("async_reset_index", 32'(index), 32'd0);
    check("async_reset_changed", 32'(changed), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    push_steps(1'b1, t0, t0 + 16);
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    repeat (15) @(negedge clk);
    check("post_reset_index", 32'(index), 32'd1);

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/speed_selector.md
SPEED_SELECTOR -- requirements
Module: speed_selector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before a debounced button level changes.
REQ-002 Parameter REPEAT_DELAY, default 10000000: cycles a single button is held before auto-repeat starts.
REQ-003 Parameter REPEAT_PERIOD, default 2000000: cycles between auto-repeat steps.
REQ-004 Parameter RESET_INDEX, default 8'd0: index value after reset.
REQ-005 i_clkPin  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_rst  input  1  reset, asynchronous, active-high.
REQ-007 i_ena  input  1  enable; when low, all state holds.
REQ-008 i_btnUp  input  1  raw up button, asynchronous, bouncy, active-high.
REQ-009 i_btnDown  input  1  raw down button, asynchronous, bouncy, active-high.
REQ-010 o_indexSelectLine  output  8  registered speed index, drives the clock divider select input.
REQ-011 o_changed  output  1  one-cycle pulse in the cycle o_indexSelectLine takes a new value.

Function
REQ-012 Each button passes through a two-flop synchronizer before any other logic.
REQ-013 Debouncer: the stable level updates to the synchronized level after exactly DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreement restarts the count at 0.
REQ-014 Press event = debounced level 0->1; release events cause no index change.
REQ-015 Up step: index+1, saturating at 255; down step: index-1, saturating at 0; a saturated step leaves the index unchanged and asserts no o_changed.
REQ-016 Up and down steps in the same cycle cancel: no change, no pulse.
REQ-017 Repeat FSM states IDLE, DELAY, REPEAT, with a latched direction (UP/DOWN) and a delay/period counter wide enough for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-018 IDLE -> DELAY on a press event while the other debounced button is low: issue one step immediately, latch direction, clear counter.
REQ-019 DELAY -> REPEAT when the counter reaches REPEAT_DELAY-1: issue one step, clear counter.
REQ-020 In REPEAT, issue one step each time the counter reaches REPEAT_PERIOD-1, then clear the counter.
REQ-021 DELAY or REPEAT -> IDLE, with no step, when the latched button releases or the opposite debounced button goes high.
REQ-022 A press event with both debounced buttons high produces no step, and the FSM stays in or returns to IDLE.
REQ-023 Index update latency: o_indexSelectLine changes on the clock edge after the step is generated internally; o_changed is asserted in that same cycle.
REQ-024 While i_ena is low: synchronizers run, while debounce counters, FSM, counters and the index hold; o_changed is 0.

Reset
REQ-025 While i_rst is high: o_indexSelectLine=RESET_INDEX, o_changed=0, FSM=IDLE, all counters=0, debounced levels=0, synchronizer flops=0.
REQ-026 Reset asserted mid-hold aborts repeat. After release, a button still held produces one press event after debounce, because the debounced level restarts at 0.

Structure
REQ-027 Package speed_selector_pkg holds the FSM state enum, the direction enum and the default parameter constants.
REQ-028 Sub-module button_debouncer (synchronizer + debounce counter + rising-edge pulse) is instantiated twice.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
REQ-029 Reset, then up held clean for 10 cycles -> index 0->1 exactly 6 cycles after the first high sample (2 sync + 4 debounce), with one o_changed pulse.
REQ-030 Up toggling every 2 cycles for 30 cycles, then low -> index unchanged, no o_changed.
REQ-031 Up held 60 cycles from index 0 -> steps at press, +20 cycles, then every 5 cycles; final index 1+1+7=9 and 9 pulses.
REQ-032 Index 255 plus up press, and index 0 plus down press -> index unchanged, no pulse.
REQ-033 Up held in REPEAT, then down pressed -> repeat stops, index frozen, FSM IDLE; both buttons held simultaneously from idle -> no change.
REQ-034 i_rst pulsed high asynchronously mid-REPEAT at index 40 -> index RESET_INDEX immediately, no o_changed, next step only after a fresh debounce.
